// File: rtl/fx2_pkg.sv
// Shared types and helpers for the FX2 stream arbiter: FSM encoding,
// default packet/timeout constants and byte-lane selection.
package fx2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BYTE0  = 3'd1,
        ST_BYTE1  = 3'd2,
        ST_BYTE2  = 3'd3,
        ST_BYTE3  = 3'd4,
        ST_PKTEND = 3'd5
    } fx2_state_t;

    localparam int DEF_PKT_BYTES = 512;
    localparam int DEF_TIMEOUT   = 4800;

    // True while a latched word is being shifted out, i.e. slwr_n is low.
    function automatic logic is_word_state(input fx2_state_t st);
        is_word_state = (st == ST_BYTE0) || (st == ST_BYTE1) ||
                        (st == ST_BYTE2) || (st == ST_BYTE3);
    endfunction

    // Little-endian lane for the byte presented in a given BYTEn state.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input fx2_state_t st);
        case (st)
            ST_BYTE1: byte_lane = word[15:8];
            ST_BYTE2: byte_lane = word[23:16];
            ST_BYTE3: byte_lane = word[31:24];
            default:  byte_lane = word[7:0];
        endcase
    endfunction

endpackage

// File: rtl/fx2_stream_arbiter_if.sv
// Word-source handshakes plus the FX2 slave-FIFO write bus, bundled so the
// arbiter (master) and its environment (slave) share one port.
interface fx2_stream_arbiter_if;

    // srcN_valid/srcN_ready: a word moves in the cycle where both are 1 on the
    // rising clk edge; a source holds data and valid stable until that cycle and
    // ready may be asserted without valid never implying a transfer.
    logic [31:0] src0_data;
    logic        src0_valid;
    logic        src0_ready;
    logic [31:0] src1_data;
    logic        src1_valid;
    logic        src1_ready;

    logic        flag_full_n;
    logic [7:0]  fd;
    logic        slwr_n;
    logic        pktend_n;
    logic        slrd_n;
    logic        sloe_n;
    logic [1:0]  fifoadr;

    modport master (
        input  src0_data, src0_valid, src1_data, src1_valid, flag_full_n,
        output src0_ready, src1_ready, fd, slwr_n, pktend_n, slrd_n, sloe_n, fifoadr
    );

    modport slave (
        output src0_data, src0_valid, src1_data, src1_valid, flag_full_n,
        input  src0_ready, src1_ready, fd, slwr_n, pktend_n, slrd_n, sloe_n, fifoadr
    );

endinterface

// File: rtl/fx2_rr_arb2.sv
// Two-requester round-robin arbiter: on contention the requester not granted
// last wins; the history only moves when a grant is actually used.
module fx2_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // 1 = requester 1 was granted most recently, so requester 0 is favoured.
    logic r_last;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (advance) begin
            r_last <= grant[1];
        end
    end

endmodule

// File: rtl/fx2_stream_arbiter.sv
// Streams two 32-bit word sources into an FX2 slave FIFO one byte per clock,
// committing short packets on flush or after an idle timeout.
module fx2_stream_arbiter
    import fx2_pkg::*;
#(
    parameter int         PKT_BYTES = DEF_PKT_BYTES,
    parameter int         TIMEOUT   = DEF_TIMEOUT,
    parameter logic [1:0] EP_ADDR   = 2'b00
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 flush,
    fx2_stream_arbiter_if.master bus,
    output logic                 busy,
    output logic [15:0]          pktend_count,
    output fx2_state_t           dbg_state,
    output logic [10:0]          dbg_byte_cnt
);

    localparam int CNT_W  = $clog2(PKT_BYTES);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    fx2_state_t        r_state;
    fx2_state_t        w_next_state;
    logic              r_run;
    logic [31:0]       r_word;
    logic [CNT_W-1:0]  r_byte_cnt;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic              r_flush_lat;
    logic [7:0]        r_fd;
    logic              r_slwr_n;
    logic              r_pktend_n;
    logic              r_busy;
    logic [15:0]       r_pktend_count;

    logic              w_in_word;
    logic              w_next_in_word;
    logic              w_cnt_nz;
    logic              w_timeout;
    logic              w_pending;
    logic              w_window;
    logic              w_xfer;
    logic              w_go_pktend;
    logic [1:0]        w_req;
    logic [1:0]        w_grant;
    logic [31:0]       w_sel_data;
    logic [31:0]       w_next_word;

    assign w_in_word      = is_word_state(r_state);
    assign w_next_in_word = is_word_state(w_next_state);
    assign w_cnt_nz       = (r_byte_cnt != '0);
    assign w_timeout      = (r_idle_cnt == IDLE_W'(TIMEOUT));

    // A commit only means something while the FX2 holds uncommitted bytes.
    assign w_pending = (flush || r_flush_lat || w_timeout) && w_cnt_nz;

    // r_run keeps ready low until the first clock after reset release.
    assign w_window = r_run && enable && bus.flag_full_n && !w_pending &&
                      ((r_state == ST_IDLE) || (r_state == ST_BYTE3));

    assign w_req       = {bus.src1_valid, bus.src0_valid} & {2{w_window}};
    assign w_xfer      = |w_grant;
    assign w_sel_data  = w_grant[1] ? bus.src1_data : bus.src0_data;
    assign w_next_word = w_xfer ? w_sel_data : r_word;
    assign w_go_pktend = (r_state == ST_IDLE) && w_pending && bus.flag_full_n;

    fx2_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (reset_n),
        .req     (w_req),
        .advance (w_xfer),
        .grant   (w_grant)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_go_pktend) begin
                    w_next_state = ST_PKTEND;
                end else if (w_xfer) begin
                    w_next_state = ST_BYTE0;
                end
            end
            ST_BYTE0:  w_next_state = ST_BYTE1;
            ST_BYTE1:  w_next_state = ST_BYTE2;
            ST_BYTE2:  w_next_state = ST_BYTE3;
            ST_BYTE3:  w_next_state = w_xfer ? ST_BYTE0 : ST_IDLE;
            ST_PKTEND: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_run   <= 1'b0;
            r_word  <= '0;
        end else begin
            r_state <= w_next_state;
            r_run   <= 1'b1;
            if (w_xfer) begin
                r_word <= w_sel_data;
            end
        end
    end

    // Bus outputs are launched from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fd           <= '0;
            r_slwr_n       <= 1'b1;
            r_pktend_n     <= 1'b1;
            r_busy         <= 1'b0;
            r_pktend_count <= '0;
        end else begin
            r_slwr_n   <= !w_next_in_word;
            r_pktend_n <= !w_go_pktend;
            r_busy     <= (w_next_state != ST_IDLE);
            if (w_next_in_word) begin
                r_fd <= byte_lane(w_next_word, w_next_state);
            end
            if (w_go_pktend) begin
                r_pktend_count <= r_pktend_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_byte_cnt  <= '0;
            r_idle_cnt  <= '0;
            r_flush_lat <= 1'b0;
        end else begin
            // Power-of-two width makes the wrap match FX2 auto-commit.
            if (w_go_pktend) begin
                r_byte_cnt <= '0;
            end else if (w_in_word) begin
                r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end

            if (w_go_pktend || w_xfer || !w_cnt_nz) begin
                r_idle_cnt <= '0;
            end else if ((r_state == ST_IDLE) && !w_timeout) begin
                r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end

            if (w_go_pktend) begin
                r_flush_lat <= 1'b0;
            end else if (flush && (w_in_word || w_xfer || w_cnt_nz)) begin
                r_flush_lat <= 1'b1;
            end else if (((r_state == ST_IDLE) || (r_state == ST_PKTEND)) &&
                         !w_cnt_nz && !w_xfer) begin
                r_flush_lat <= 1'b0;
            end
        end
    end

    assign bus.src0_ready = w_grant[0];
    assign bus.src1_ready = w_grant[1];
    assign bus.fd         = r_fd;
    assign bus.slwr_n     = r_slwr_n;
    assign bus.pktend_n   = r_pktend_n;
    assign bus.slrd_n     = 1'b1;
    assign bus.sloe_n     = 1'b1;
    assign bus.fifoadr    = EP_ADDR;

    assign busy         = r_busy;
    assign pktend_count = r_pktend_count;
    assign dbg_state    = r_state;
    assign dbg_byte_cnt = 11'(r_byte_cnt);

endmodule

// File: tb/tb_fx2_stream_arbiter.sv
// Directed bench for fx2_stream_arbiter: expected FX2 bytes and pktend markers
// are queued as stimulus is issued and consumed by a negedge bus monitor.
module tb_fx2_stream_arbiter;
    import fx2_pkg::*;

    localparam int TB_PKT_BYTES = 512;
    localparam int TB_TIMEOUT   = 16;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        flush;
    logic        busy;
    logic [15:0] pktend_count;
    fx2_state_t  dbg_state;
    logic [10:0] dbg_byte_cnt;

    fx2_stream_arbiter_if bus ();

    fx2_stream_arbiter #(
        .PKT_BYTES (TB_PKT_BYTES),
        .TIMEOUT   (TB_TIMEOUT),
        .EP_ADDR   (2'b10)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .flush        (flush),
        .bus          (bus),
        .busy         (busy),
        .pktend_count (pktend_count),
        .dbg_state    (dbg_state),
        .dbg_byte_cnt (dbg_byte_cnt)
    );

    // ---- clock ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- scoreboard state; bit 8 set = pktend marker ----
    logic [8:0]  exp_q[$];
    logic [31:0] src0_q[$];
    logic [31:0] src1_q[$];
    int n_vec = 0;
    int n_err = 0;
    int mon_cyc = 0;
    int n_wr = 0;
    int first_wr = -1;
    int last_wr = -1;
    int pk_cyc = -1;
    int n_pk = 0;
    logic s_rdy0;
    logic s_rdy1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- monitor ----
    always @(negedge clk) begin
        logic [8:0] e;
        mon_cyc++;
        if (reset_n) begin
            if (!bus.slwr_n) begin
                n_wr++;
                if (first_wr < 0) first_wr = mon_cyc;
                last_wr = mon_cyc;
                if (exp_q.size() == 0) begin
                    check("fd_unexpected_write", {24'h0, bus.fd}, 32'h1ff);
                end else begin
                    e = exp_q.pop_front();
                    check("fd", {23'h0, 1'b0, bus.fd}, {23'h0, e});
                end
            end
            if (!bus.pktend_n) begin
                n_pk++;
                pk_cyc = mon_cyc;
                if (exp_q.size() == 0) begin
                    check("pktend_unexpected", 32'h0, 32'h100);
                end else begin
                    e = exp_q.pop_front();
                    check("pktend_order", {23'h0, e}, 32'h100);
                end
            end
        end
    end

    // ---- driver tasks ----
    task automatic present();
        bus.src0_valid = (src0_q.size() > 0);
        bus.src0_data  = (src0_q.size() > 0) ? src0_q[0] : 32'h0;
        bus.src1_valid = (src1_q.size() > 0);
        bus.src1_data  = (src1_q.size() > 0) ? src1_q[0] : 32'h0;
    endtask

    task automatic step();
        logic t0;
        logic t1;
        @(negedge clk);
        t0 = bus.src0_valid && bus.src0_ready;
        t1 = bus.src1_valid && bus.src1_ready;
        s_rdy0 = bus.src0_ready;
        s_rdy1 = bus.src1_ready;
        @(posedge clk);
        #1;
        if (t0 && src0_q.size() > 0) void'(src0_q.pop_front());
        if (t1 && src1_q.size() > 0) void'(src1_q.pop_front());
        present();
    endtask

    task automatic load(input int src, input logic [31:0] w);
        if (src == 0) src0_q.push_back(w);
        else src1_q.push_back(w);
        present();
    endtask

    task automatic expect_word(input logic [31:0] w);
        exp_q.push_back({1'b0, w[7:0]});
        exp_q.push_back({1'b0, w[15:8]});
        exp_q.push_back({1'b0, w[23:16]});
        exp_q.push_back({1'b0, w[31:24]});
    endtask

    task automatic expect_pktend();
        exp_q.push_back(9'h100);
    endtask

    task automatic mark();
        n_wr = 0;
        first_wr = -1;
        last_wr = -1;
        pk_cyc = -1;
        n_pk = 0;
    endtask

    task automatic drain(input int budget, input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            step();
            k++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic wait_state(input fx2_state_t st, input int budget, input string name);
        int k;
        k = 0;
        while (dbg_state != st && k < budget) begin
            step();
            k++;
        end
        check({name, "_reach_state"}, dbg_state, st);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable = 1'b1;
        flush = 1'b0;
        bus.flag_full_n = 1'b1;
        src0_q.delete();
        src1_q.delete();
        exp_q.delete();
        present();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        mark();
    endtask

    // ---- watchdog ----
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end

    // ---- main sequence ----
    initial begin
        // Reset values, with both sources valid to show ready stays low.
        reset_n = 1'b0;
        enable = 1'b1;
        flush = 1'b0;
        bus.flag_full_n = 1'b1;
        bus.src0_valid = 1'b1;
        bus.src0_data = $urandom;
        bus.src1_valid = 1'b1;
        bus.src1_data = $urandom;
        #12;
        check("rst_slwr_n", bus.slwr_n, 1);
        check("rst_pktend_n", bus.pktend_n, 1);
        check("rst_fd", bus.fd, 0);
        check("rst_ready0", bus.src0_ready, 0);
        check("rst_ready1", bus.src1_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_pktend_count", pktend_count, 0);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_byte_cnt", dbg_byte_cnt, 0);
        check("rst_slrd_n", bus.slrd_n, 1);
        check("rst_sloe_n", bus.sloe_n, 1);
        check("rst_fifoadr", bus.fifoadr, 2'b10);

        // src0 streams two words back to back, then flush commits them.
        do_reset();
        load(0, 32'h44332211);
        load(0, 32'h88776655);
        expect_word(32'h44332211);
        expect_word(32'h88776655);
        drain(40, "t1");
        check("t1_writes", n_wr, 8);
        check("t1_contiguous", last_wr - first_wr, 7);
        check("t1_byte_cnt", dbg_byte_cnt, 8);
        flush = 1'b1;
        expect_pktend();
        step();
        flush = 1'b0;
        drain(20, "t1_flush");
        check("t1_pktend_count", pktend_count, 1);
        check("t1_byte_cnt_clr", dbg_byte_cnt, 0);

        // Both sources always valid: grants alternate starting with src0.
        do_reset();
        mark();
        load(0, 32'hA3A2A1A0);
        load(0, 32'hA7A6A5A4);
        load(0, 32'hABAAA9A8);
        load(1, 32'hB3B2B1B0);
        load(1, 32'hB7B6B5B4);
        load(1, 32'hBBBAB9B8);
        expect_word(32'hA3A2A1A0);
        expect_word(32'hB3B2B1B0);
        expect_word(32'hA7A6A5A4);
        expect_word(32'hB7B6B5B4);
        expect_word(32'hABAAA9A8);
        expect_word(32'hBBBAB9B8);
        drain(80, "t2");
        check("t2_writes", n_wr, 24);
        check("t2_contiguous", last_wr - first_wr, 23);
        check("t2_byte_cnt", dbg_byte_cnt, 24);
        flush = 1'b1;
        expect_pktend();
        step();
        flush = 1'b0;
        drain(20, "t2_flush");
        check("t2_pktend_count", pktend_count, 1);

        // One word from src1 alone, then idle: 17 IDLE cycles (idle_cnt 0..16)
        // separate the last byte from the PKTEND cycle, i.e. 18 clocks apart.
        do_reset();
        load(1, 32'hDEADBEEF);
        expect_word(32'hDEADBEEF);
        expect_pktend();
        drain(60, "t3");
        check("t3_pktend_delay", pk_cyc - last_wr, 18);
        repeat (TB_TIMEOUT + 4) step();
        check("t3_single_pulse", n_pk, 1);
        check("t3_pktend_count", pktend_count, 1);
        check("t3_byte_cnt", dbg_byte_cnt, 0);

        // 128 words fill exactly one 512-byte packet: counter wraps, no timeout.
        do_reset();
        for (int i = 0; i < 128; i++) begin
            logic [31:0] w;
            w = {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
            load(0, w);
            expect_word(w);
        end
        drain(600, "t4");
        check("t4_writes", n_wr, 512);
        check("t4_contiguous", last_wr - first_wr, 511);
        check("t4_byte_cnt_wrap", dbg_byte_cnt, 0);
        repeat (TB_TIMEOUT + 6) step();
        check("t4_no_pktend", n_pk, 0);
        check("t4_pktend_count", pktend_count, 0);

        // FIFO full mid-word, flush mid-word: word finishes, commit precedes
        // the next word once space returns.
        do_reset();
        load(0, 32'h04030201);
        load(0, 32'h08070605);
        expect_word(32'h04030201);
        expect_pktend();
        expect_word(32'h08070605);
        wait_state(ST_BYTE1, 10, "t5");
        bus.flag_full_n = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("t5_no_ready_while_full", s_rdy0, 0);
        end
        check("t5_word_completed", n_wr, 4);
        check("t5_no_pktend_while_full", n_pk, 0);
        bus.flag_full_n = 1'b1;
        drain(40, "t5");
        check("t5_pktend_count", pktend_count, 1);
        check("t5_byte_cnt", dbg_byte_cnt, 4);

        // Reset during BYTE2 aborts the word; an empty-packet flush is ignored.
        do_reset();
        load(0, 32'hCAFEF00D);
        expect_word(32'hCAFEF00D);
        wait_state(ST_BYTE2, 10, "t6");
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_slwr_n", bus.slwr_n, 1);
        check("t6_async_busy", busy, 0);
        check("t6_async_state", dbg_state, ST_IDLE);
        check("t6_bytes_before_reset", n_wr, 2);
        exp_q.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (TB_TIMEOUT + 4) step();
        check("t6_byte_cnt", dbg_byte_cnt, 0);
        check("t6_pktend_count", pktend_count, 0);
        check("t6_no_pktend", n_pk, 0);
        check("t6_no_replay", n_wr, 2);
        check("t6_busy", busy, 0);

        check("final_exp_q_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
